// File: rtl/router_reg.sv
// router_reg: 1x3 router datapath register block (header, full-buffer, parity).
// Build option: ROUTER_REG_STICKY_ERR_EN keeps err set until resetn.
module router_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             pkt_valid,
  input  logic             fifo_full,
  input  logic             rst_int_reg,
  input  logic             detect_add,
  input  logic             ld_state,
  input  logic             laf_state,
  input  logic             full_state,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic             parity_done,
  output logic             low_pkt_valid,
  output logic             err,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] hdr;
  logic [WIDTH-1:0] ffb;
  logic [WIDTH-1:0] int_par;
  logic [WIDTH-1:0] pkt_par;
  logic             hdr_ok;

  assign hdr_ok = detect_add && pkt_valid
               && (data_in[1:0] != 2'b11);

  // Latch header byte of a packet with a valid address
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hdr <= '0;
    end else if (hdr_ok) begin
      hdr <= data_in;
    end
  end

  // Park the byte that arrives while the FIFO is full
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ffb <= '0;
    end else if (ld_state && fifo_full) begin
      ffb <= data_in;
    end
  end

  // FIFO write bus: header, live byte, or replayed parked byte
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dout <= '0;
    end else begin
      unique case (1'b1)
        lfd_state:               dout <= hdr;
        (ld_state && !fifo_full): dout <= data_in;
        laf_state:               dout <= ffb;
        default:                 dout <= dout;
      endcase
    end
  end

  // Source dropped pkt_valid during payload load
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      low_pkt_valid <= 1'b0;
    end else if (rst_int_reg) begin
      low_pkt_valid <= 1'b0;
    end else if (ld_state && !pkt_valid) begin
      low_pkt_valid <= 1'b1;
    end
  end

  // Parity byte consumed, directly or after a full stall
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      parity_done <= 1'b0;
    end else if (detect_add) begin
      parity_done <= 1'b0;
    end else if (ld_state && !fifo_full && !pkt_valid) begin
      parity_done <= 1'b1;
    end else if (laf_state && low_pkt_valid
                 && !parity_done) begin
      parity_done <= 1'b1;
    end
  end

  // Running XOR over header and accepted payload bytes
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      int_par <= '0;
    end else if (detect_add) begin
      int_par <= '0;
    end else if (lfd_state && pkt_valid) begin
      int_par <= int_par ^ hdr;
    end else if (ld_state && pkt_valid
                 && !full_state && !fifo_full) begin
      int_par <= int_par ^ data_in;
    end
  end

  // Capture the received parity byte
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pkt_par <= '0;
    end else if (detect_add) begin
      pkt_par <= '0;
    end else if (ld_state && !pkt_valid && !fifo_full) begin
      pkt_par <= data_in;
    end
  end

  // Parity compare, valid the cycle after parity_done
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      err <= 1'b0;
`ifdef ROUTER_REG_STICKY_ERR_EN
    end else if (parity_done && (int_par != pkt_par)) begin
      err <= 1'b1;
    end
`else
    end else if (parity_done) begin
      err <= (int_par != pkt_par);
    end else if (detect_add) begin
      err <= 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_router_reg.sv
// tb_router_reg: directed table plus randomized model check of router_reg.
// Honours ROUTER_REG_STICKY_ERR_EN to match the DUT build.
module tb_router_reg;

  localparam int W = 8;
`ifdef ROUTER_REG_STICKY_ERR_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  localparam logic [2:0] S_NONE = 3'd0;
  localparam logic [2:0] S_DET  = 3'd1;
  localparam logic [2:0] S_LFD  = 3'd2;
  localparam logic [2:0] S_LD   = 3'd3;
  localparam logic [2:0] S_LAF  = 3'd4;
  localparam logic [2:0] S_FULL = 3'd5;

  logic         clock;
  logic         resetn;
  logic         pkt_valid;
  logic         fifo_full;
  logic         rst_int_reg;
  logic         detect_add;
  logic         ld_state;
  logic         laf_state;
  logic         full_state;
  logic         lfd_state;
  logic [W-1:0] data_in;
  logic         parity_done;
  logic         low_pkt_valid;
  logic         err;
  logic [W-1:0] dout;

  int n_chk;
  int n_fail;

  router_reg #(.WIDTH(W)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .pkt_valid    (pkt_valid),
    .fifo_full    (fifo_full),
    .rst_int_reg  (rst_int_reg),
    .detect_add   (detect_add),
    .ld_state     (ld_state),
    .laf_state    (laf_state),
    .full_state   (full_state),
    .lfd_state    (lfd_state),
    .data_in      (data_in),
    .parity_done  (parity_done),
    .low_pkt_valid(low_pkt_valid),
    .err          (err),
    .dout         (dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] st;
    logic       pv;
    logic       ff;
    logic       ri;
    logic [7:0] d;
    logic [7:0] e_dout;
    logic       e_pd;
    logic       e_lpv;
    logic       e_err;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [2:0] st, input logic pv,
                     input logic ff, input logic ri,
                     input logic [7:0] d, input logic [7:0] ed,
                     input logic pd, input logic lpv,
                     input logic e);
    vec_t v;
    v.st = st; v.pv = pv; v.ff = ff; v.ri = ri; v.d = d;
    v.e_dout = ed; v.e_pd = pd; v.e_lpv = lpv; v.e_err = e;
    vq.push_back(v);
  endtask

  task automatic drive(input logic [2:0] st, input logic pv,
                       input logic ff, input logic ri,
                       input logic [7:0] d);
    detect_add  = (st == S_DET);
    lfd_state   = (st == S_LFD);
    ld_state    = (st == S_LD);
    laf_state   = (st == S_LAF);
    full_state  = (st == S_FULL);
    pkt_valid   = pv;
    fifo_full   = ff;
    rst_int_reg = ri;
    data_in     = d;
  endtask

  // Behavioural reference: parity kept as list of accepted bytes
  logic [7:0] m_hdr, m_ffb, m_dout, m_ppar;
  logic       m_lpv, m_pd, m_err;
  logic [7:0] m_q[$];

  function automatic logic [7:0] q_xor();
    logic [7:0] x;
    x = 8'h00;
    foreach (m_q[i]) x = x ^ m_q[i];
    return x;
  endfunction

  task automatic m_reset();
    m_hdr = 0; m_ffb = 0; m_dout = 0; m_ppar = 0;
    m_lpv = 0; m_pd = 0; m_err = 0;
    m_q.delete();
  endtask

  task automatic m_step(input logic [2:0] st, input logic pv,
                        input logic ff, input logic ri,
                        input logic [7:0] d);
    logic [7:0] n_hdr, n_ffb, n_dout, n_ppar, ipar;
    logic       n_lpv, n_pd, n_err, mism;
    ipar = q_xor();
    mism = (ipar != m_ppar);
    n_hdr = m_hdr; n_ffb = m_ffb; n_dout = m_dout;
    n_ppar = m_ppar; n_lpv = m_lpv; n_pd = m_pd; n_err = m_err;
    if (st == S_DET && pv && d[1:0] != 2'b11) n_hdr = d;
    if (st == S_LD && ff) n_ffb = d;
    if (st == S_LFD) n_dout = m_hdr;
    else if (st == S_LD && !ff) n_dout = d;
    else if (st == S_LAF) n_dout = m_ffb;
    if (ri) n_lpv = 0;
    else if (st == S_LD && !pv) n_lpv = 1;
    if (st == S_DET) n_pd = 0;
    else if (st == S_LD && !ff && !pv) n_pd = 1;
    else if (st == S_LAF && m_lpv && !m_pd) n_pd = 1;
    if (st == S_DET) n_ppar = 0;
    else if (st == S_LD && !pv && !ff) n_ppar = d;
    if (STK) begin
      if (m_pd && mism) n_err = 1;
    end else begin
      if (m_pd) n_err = mism;
      else if (st == S_DET) n_err = 0;
    end
    if (st == S_DET) m_q.delete();
    else if (st == S_LFD && pv) m_q.push_back(m_hdr);
    else if (st == S_LD && pv && !ff) m_q.push_back(d);
    m_hdr = n_hdr; m_ffb = n_ffb; m_dout = n_dout;
    m_ppar = n_ppar; m_lpv = n_lpv; m_pd = n_pd; m_err = n_err;
  endtask

  task automatic check_outs(input string tag,
                            input logic [7:0] ed, input logic pd,
                            input logic lpv, input logic e);
    chk({tag, ".dout"}, 32'(dout), 32'(ed));
    chk({tag, ".parity_done"}, 32'(parity_done), 32'(pd));
    chk({tag, ".low_pkt_valid"}, 32'(low_pkt_valid), 32'(lpv));
    chk({tag, ".err"}, 32'(err), 32'(e));
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    resetn = 1'b0;
    drive(S_NONE, 0, 0, 0, 8'h00);

    // good packet: 05 ^ 07 ^ 08 = 0A
    add(S_DET,  1, 0, 0, 8'h05, 8'h00, 0, 0, 0);
    add(S_LFD,  1, 0, 0, 8'h00, 8'h05, 0, 0, 0);
    add(S_LD,   1, 0, 0, 8'h07, 8'h07, 0, 0, 0);
    add(S_LD,   1, 0, 0, 8'h08, 8'h08, 0, 0, 0);
    add(S_LD,   0, 0, 0, 8'h0A, 8'h0A, 1, 1, 0);
    add(S_NONE, 0, 0, 0, 8'h00, 8'h0A, 1, 1, 0);
    add(S_NONE, 0, 0, 1, 8'h00, 8'h0A, 1, 0, 0);
    // bad parity packet
    add(S_DET,  1, 0, 0, 8'h05, 8'h0A, 0, 0, 0);
    add(S_LFD,  1, 0, 0, 8'h00, 8'h05, 0, 0, 0);
    add(S_LD,   1, 0, 0, 8'h07, 8'h07, 0, 0, 0);
    add(S_LD,   1, 0, 0, 8'h08, 8'h08, 0, 0, 0);
    add(S_LD,   0, 0, 0, 8'h0B, 8'h0B, 1, 1, 0);
    add(S_NONE, 0, 0, 0, 8'h00, 8'h0B, 1, 1, 1);
    add(S_NONE, 0, 0, 0, 8'h00, 8'h0B, 1, 1, 1);
    add(S_NONE, 0, 0, 1, 8'h00, 8'h0B, 1, 0, 1);
    // first decode still sees parity_done; second clears err
    add(S_DET,  1, 0, 0, 8'h05, 8'h0B, 0, 0, 1);
    add(S_DET,  1, 0, 0, 8'h05, 8'h0B, 0, 0, STK);
    // full stall: 05 ^ 07 ^ 02 = 00
    add(S_LFD,  1, 0, 0, 8'h00, 8'h05, 0, 0, STK);
    add(S_LD,   1, 0, 0, 8'h07, 8'h07, 0, 0, STK);
    add(S_LD,   1, 1, 0, 8'h02, 8'h07, 0, 0, STK);
    add(S_FULL, 1, 1, 0, 8'h02, 8'h07, 0, 0, STK);
    add(S_LAF,  1, 0, 0, 8'h02, 8'h02, 0, 0, STK);
    add(S_LD,   1, 0, 0, 8'h02, 8'h02, 0, 0, STK);
    add(S_LD,   0, 0, 0, 8'h00, 8'h00, 1, 1, STK);
    add(S_NONE, 0, 0, 0, 8'h00, 8'h00, 1, 1, STK);
    // invalid address 3 keeps old header 05
    add(S_NONE, 0, 0, 1, 8'h00, 8'h00, 1, 0, STK);
    add(S_DET,  1, 0, 0, 8'h07, 8'h00, 0, 0, STK);
    add(S_LFD,  1, 0, 0, 8'h00, 8'h05, 0, 0, STK);
    // parity byte arrives while full, done via LOAD_AFTER_FULL
    add(S_LD,   0, 1, 0, 8'h33, 8'h05, 0, 1, STK);
    add(S_LAF,  0, 0, 0, 8'h00, 8'h33, 1, 1, STK);
    add(S_NONE, 0, 0, 0, 8'h00, 8'h33, 1, 1, 1);

    repeat (2) @(posedge clock);
    #1;
    check_outs("reset", 8'h00, 0, 0, 0);
    resetn = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].st, vq[i].pv, vq[i].ff, vq[i].ri, vq[i].d);
      @(posedge clock);
      #1;
      check_outs($sformatf("vec%0d", i), vq[i].e_dout,
                 vq[i].e_pd, vq[i].e_lpv, vq[i].e_err);
    end

    // asynchronous reset mid-cycle, checked before the next edge
    drive(S_NONE, 0, 0, 0, 8'h00);
    #2;
    resetn = 1'b0;
    #1;
    check_outs("async_rst", 8'h00, 0, 0, 0);
    #1;
    @(negedge clock);
    resetn = 1'b1;
    m_reset();

    for (int c = 0; c < 3000; c++) begin
      logic [2:0] st;
      logic       pv, ff, ri;
      logic [7:0] d;
      st = 3'($urandom_range(0, 5));
      pv = 1'($urandom_range(0, 3) != 0);
      ff = 1'($urandom_range(0, 3) == 0);
      ri = 1'($urandom_range(0, 7) == 0);
      d  = 8'($urandom);
      drive(st, pv, ff, ri, d);
      m_step(st, pv, ff, ri, d);
      @(posedge clock);
      #1;
      check_outs($sformatf("rnd%0d", c), m_dout, m_pd,
                 m_lpv, m_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
